demux_pack: RTL and testbench

Parametrised successor of the 16-to-32 channel DDR demultiplexer in the capture path. Each sample strobe takes either a rising/falling sample pair (DDR mode) or a single rising-edge sample (SDR mode). It packs PACK·2 channel-width slots into one wide word and emits that word with a single-cycle valid pulse. It sits between the input synchroniser/sampler and the trigger/RAM-write path, so downstream logic can run at a reduced word rate.

---
 rtl/demux_pack_if.sv | 26 ++
 rtl/demux_pack.sv | 86 ++++++++
 tb/tb_demux_pack.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_pack_if.sv
// Capture-path bus between the sampler and demux_pack: sample inputs in, packed words out.
// The master drives strobes and samples; the slave returns completed words.
interface demux_pack_if #(
    parameter int CHANNELS = 16,
    parameter int PACK     = 1
);
    localparam int OUT_W = CHANNELS * 2 * PACK;

    logic                ddr_mode;
    logic                sample_en;
    logic                flush;
    logic [CHANNELS-1:0] indata;
    logic [CHANNELS-1:0] indata180;
    logic [OUT_W-1:0]    outdata;
    logic                outvalid;

    modport master (
        output ddr_mode, sample_en, flush, indata, indata180,
        input  outdata, outvalid
    );

    modport slave (
        input  ddr_mode, sample_en, flush, indata, indata180,
        output outdata, outvalid
    );
endinterface

// File: rtl/demux_pack.sv
// Packs SDR samples or DDR rising/falling sample pairs into 2*PACK-slot words.
// Each completed word is emitted with a single-cycle outvalid pulse; slot 0 is the oldest sample.
module demux_pack #(
    parameter int CHANNELS = 16,
    parameter int PACK     = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    demux_pack_if.slave  bus
);
    localparam int SLOTS = 2 * PACK;
    localparam int CW    = $clog2(SLOTS) + 1;
    localparam int OUT_W = CHANNELS * SLOTS;

    logic [CHANNELS-1:0] r_dly180;
    logic                r_ddr_q;
    logic [CW-1:0]       r_cnt;
    logic [OUT_W-1:0]    r_asm;
    logic [OUT_W-1:0]    r_outdata;
    logic                r_outvalid;

    logic                w_mode_chg;
    logic                w_strobe;
    logic                w_done;
    logic [CW-1:0]       w_cnt_eff;
    logic [CW-1:0]       w_step;
    logic [CW-1:0]       w_cnt_sum;
    logic [CW-1:0]       w_cnt_next;
    logic [OUT_W-1:0]    w_asm_next;

    // A mode change throws the partial word away; a strobe in that cycle starts a fresh word.
    assign w_mode_chg = (bus.ddr_mode != r_ddr_q);
    assign w_cnt_eff  = w_mode_chg ? '0 : r_cnt;
    assign w_strobe   = bus.sample_en & ~bus.flush;
    assign w_step     = bus.ddr_mode ? CW'(2) : CW'(1);
    assign w_cnt_sum  = w_cnt_eff + w_step;
    assign w_done     = w_strobe && (w_cnt_sum >= CW'(SLOTS));

    always_comb begin
        w_cnt_next = w_cnt_eff;
        if (bus.flush) begin
            w_cnt_next = '0;
        end else if (w_strobe) begin
            w_cnt_next = w_done ? '0 : w_cnt_sum;
        end
    end

    // Per-slot write: the falling sample lands in slot cnt, the rising one in cnt+1 (DDR) or cnt (SDR).
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic w_wr_lo;
            logic w_wr_hi;
            assign w_wr_lo = w_strobe && (w_cnt_eff == CW'(gi));
            assign w_wr_hi = w_strobe && bus.ddr_mode && ((w_cnt_eff + CW'(1)) == CW'(gi));
            assign w_asm_next[gi*CHANNELS +: CHANNELS] =
                w_wr_hi ? bus.indata :
                w_wr_lo ? (bus.ddr_mode ? r_dly180 : bus.indata) :
                          r_asm[gi*CHANNELS +: CHANNELS];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dly180   <= '0;
            r_ddr_q    <= 1'b0;
            r_cnt      <= '0;
            r_asm      <= '0;
            r_outdata  <= '0;
            r_outvalid <= 1'b0;
        end else begin
            // Falling-edge sample is captured every cycle so DDR pairs always use the adjacent edge.
            r_dly180   <= bus.indata180;
            r_ddr_q    <= bus.ddr_mode;
            r_cnt      <= w_cnt_next;
            r_asm      <= w_asm_next;
            r_outvalid <= w_done;
            if (w_done) begin
                r_outdata <= w_asm_next;
            end
        end
    end

    assign bus.outdata  = r_outdata;
    assign bus.outvalid = r_outvalid;
endmodule

// File: tb/tb_demux_pack.sv
// Bench for demux_pack: a PACK=2 and a PACK=1 instance share one stimulus stream.
// A sample-list reference model feeds per-instance scoreboards checked by a negedge monitor.
module tb_demux_pack;
    logic clock;
    logic reset_n;

    demux_pack_if #(.CHANNELS(16), .PACK(2)) bus0 ();
    demux_pack_if #(.CHANNELS(16), .PACK(1)) bus1 ();

    demux_pack #(.CHANNELS(16), .PACK(2)) u0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
    demux_pack #(.CHANNELS(16), .PACK(1)) u1 (.clock(clock), .reset_n(reset_n), .bus(bus1));

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [63:0] last0 = '0;
    logic [63:0] last1 = '0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic set_inputs(input logic m, input logic en, input logic fl,
                              input logic [15:0] d, input logic [15:0] d180);
        bus0.ddr_mode = m;  bus0.sample_en = en;  bus0.flush = fl;
        bus0.indata   = d;  bus0.indata180 = d180;
        bus1.ddr_mode = m;  bus1.sample_en = en;  bus1.flush = fl;
        bus1.indata   = d;  bus1.indata180 = d180;
    endtask

    task automatic drive(input logic m, input logic en, input logic fl,
                         input logic [15:0] d, input logic [15:0] d180);
        set_inputs(m, en, fl, d, d180);
        @(negedge clock);
    endtask

    // Reset asserted and released between clock edges; outputs must clear immediately.
    task automatic do_reset(input logic m);
        set_inputs(m, 1'b0, 1'b0, 16'h0, 16'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("reset dut0 outdata", bus0.outdata, 64'h0);
        chk("reset dut0 outvalid", 64'(bus0.outvalid), 64'h0);
        chk("reset dut1 outdata", 64'(bus1.outdata), 64'h0);
        chk("reset dut1 outvalid", 64'(bus1.outvalid), 64'h0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Reference model: a word is just the list of accepted samples, oldest first.
    initial begin : model
        logic [63:0] acc [2];
        int          n [2];
        logic [15:0] prev180;
        logic        prev_mode;
        int          slots;
        exp_t        e;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                for (int d = 0; d < 2; d++) begin
                    acc[d] = '0;
                    n[d]   = 0;
                end
                prev180   = '0;
                prev_mode = 1'b0;
                exp_q0.delete();
                exp_q1.delete();
            end else begin
                cyc++;
                for (int d = 0; d < 2; d++) begin
                    slots = (d == 0) ? 4 : 2;
                    if (bus0.flush || (bus0.ddr_mode != prev_mode)) begin
                        acc[d] = '0;
                        n[d]   = 0;
                    end
                    if (bus0.sample_en && !bus0.flush) begin
                        if (bus0.ddr_mode) begin
                            acc[d] = acc[d] | (64'(prev180) << (16 * n[d]));
                            n[d]++;
                        end
                        acc[d] = acc[d] | (64'(bus0.indata) << (16 * n[d]));
                        n[d]++;
                        if (n[d] == slots) begin
                            e.data = acc[d];
                            e.cyc  = cyc;
                            if (d == 0) exp_q0.push_back(e);
                            else        exp_q1.push_back(e);
                            acc[d] = '0;
                            n[d]   = 0;
                        end
                    end
                end
                prev180   = bus0.indata180;
                prev_mode = bus0.ddr_mode;
            end
        end
    end

    task automatic mon(input int d, input logic v, input logic [63:0] od);
        exp_t        e;
        logic [63:0] last;
        int          qs;
        last = (d == 0) ? last0 : last1;
        qs   = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (v) begin
            if (qs == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut%0d unexpected word: got %h at cycle %0d, required no pulse", d, od, cyc);
            end else begin
                if (d == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                chk($sformatf("dut%0d word cycle", d), 64'(cyc), 64'(e.cyc));
                chk($sformatf("dut%0d word data", d), od, e.data);
                $display("[MON] dut%0d word %h at cycle %0d", d, od, cyc);
                if (d == 0) last0 = od;
                else        last1 = od;
            end
        end else begin
            chk($sformatf("dut%0d outdata hold", d), od, last);
            if (qs > 0) begin
                if (d == 0) e = exp_q0[0];
                else        e = exp_q1[0];
                if (e.cyc <= cyc) begin
                    if (d == 0) void'(exp_q0.pop_front());
                    else        void'(exp_q1.pop_front());
                    n_tests++;
                    n_fail++;
                    $display("FAIL dut%0d missing word: got no pulse at cycle %0d, required %h", d, cyc, e.data);
                end
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                last0 = '0;
                last1 = '0;
            end else begin
                mon(0, bus0.outvalid, bus0.outdata);
                mon(1, bus1.outvalid, {32'h0, bus1.outdata});
            end
        end
    end

    initial begin : driver
        logic [15:0] a;
        logic [15:0] prev;
        logic        m;
        reset_n = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clock);
        chk("por dut0 outdata", bus0.outdata, 64'h0);
        chk("por dut0 outvalid", 64'(bus0.outvalid), 64'h0);
        #2 reset_n = 1'b1;
        @(negedge clock);

        // DDR packing
        drive(1, 0, 0, 16'h0000, 16'h1111);
        drive(1, 1, 0, 16'h2222, 16'h3333);
        drive(1, 1, 0, 16'h4444, 16'h0000);
        chk("ddr pack outdata", bus0.outdata, 64'h4444_3333_2222_1111);
        chk("ddr pack outvalid", 64'(bus0.outvalid), 64'h1);
        drive(1, 0, 0, 16'h0000, 16'h0000);
        chk("ddr pulse width", 64'(bus0.outvalid), 64'h0);

        // Reset mid-word
        drive(1, 1, 0, 16'hBEEF, 16'h0000);
        do_reset(1'b1);
        drive(1, 0, 0, 16'h0000, 16'h0A0A);
        drive(1, 1, 0, 16'h0B0B, 16'h0C0C);
        drive(1, 1, 0, 16'h0D0D, 16'h0000);
        chk("post-reset word", bus0.outdata, 64'h0D0D_0C0C_0B0B_0A0A);

        // SDR packing with idle gaps
        drive(0, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            a = 16'h000A + 16'(i);
            drive(0, 1, 0, a, 16'($urandom));
            if (i < 3) begin
                drive(0, 0, 0, 16'($urandom), 16'($urandom));
                drive(0, 0, 0, 16'($urandom), 16'($urandom));
            end
        end
        chk("sdr pack outdata", bus0.outdata, 64'h000D_000C_000B_000A);
        chk("sdr pack outvalid", 64'(bus0.outvalid), 64'h1);

        // Flush mid-word, then flush concurrent with a strobe
        drive(1, 0, 0, 16'h0000, 16'h0001);
        drive(1, 1, 0, 16'h0002, 16'h0000);
        drive(1, 0, 1, 16'h0000, 16'h0005);
        drive(1, 1, 0, 16'h0006, 16'h0007);
        drive(1, 1, 0, 16'h0008, 16'h0000);
        chk("flush word", bus0.outdata, 64'h0008_0007_0006_0005);
        drive(1, 0, 0, 16'h0000, 16'h0010);
        drive(1, 1, 1, 16'h0099, 16'h0020);
        drive(1, 1, 0, 16'h0021, 16'h0022);
        drive(1, 1, 0, 16'h0023, 16'h0000);
        chk("flush+strobe word", bus0.outdata, 64'h0023_0022_0021_0020);

        // Mode switch SDR -> DDR with a concurrent strobe
        drive(0, 1, 0, 16'h0051, 16'h0000);
        drive(0, 1, 0, 16'h0052, 16'h0000);
        drive(0, 1, 0, 16'h0053, 16'h0061);
        drive(1, 1, 0, 16'h0062, 16'h0063);
        chk("mode switch no early word", 64'(bus0.outvalid), 64'h0);
        drive(1, 1, 0, 16'h0064, 16'h0000);
        chk("mode switch word", bus0.outdata, 64'h0064_0063_0062_0061);
        chk("mode switch outvalid", 64'(bus0.outvalid), 64'h1);

        // Continuous DDR on the PACK=1 instance
        drive(1, 0, 0, 16'h0000, 16'h00FF);
        prev = 16'h00FF;
        for (int i = 0; i < 16; i++) begin
            a = 16'hA000 + 16'(i);
            drive(1, 1, 0, a, 16'h0100 + 16'(i));
            chk("continuous outvalid", 64'(bus1.outvalid), 64'h1);
            chk("continuous outdata", 64'(bus1.outdata), {32'h0, a, prev});
            prev = 16'h0100 + 16'(i);
        end

        // Randomized traffic with occasional mode switches, flushes and one reset
        m = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) m = ~m;
            if (i == 400) do_reset(m);
            drive(m, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                  16'($urandom), 16'($urandom));
        end

        repeat (3) drive(m, 0, 0, 16'h0000, 16'h0000);
        chk("dut0 pending words", 64'(exp_q0.size()), 64'h0);
        chk("dut1 pending words", 64'(exp_q1.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
